// File: rtl/hack_pkg.sv
// -----------------------------------------------------------------------------
// hack_pkg
// Shared constants for the Hack CPU datapath blocks.
//   WORD_W       : machine word width; default width of the program counter
//   PC_RESET_VAL : value the program counter takes on rst
// -----------------------------------------------------------------------------
package hack_pkg;

  localparam int unsigned WORD_W       = 16;
  localparam logic [WORD_W-1:0] PC_RESET_VAL = '0;

endpackage : hack_pkg

// File: rtl/program_counter_inc_n.sv
// -----------------------------------------------------------------------------
// inc_n
// WIDTH-bit "+1" incrementer built as a ripple chain of half adders.
// Bit i toggles when bits 0..i-1 are all 1; the carry out of the MSB is
// exported so the caller can detect an all-ones -> zero wrap.
// Ports:
//   a    in   WIDTH  operand
//   sum  out  WIDTH  a + 1 (mod 2^WIDTH)
//   cout out  1      carry out of the MSB (1 only when a is all ones)
// -----------------------------------------------------------------------------
module inc_n
  import hack_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // w_carry[i] is the carry into bit i; the chain is seeded with the +1.
  logic [WIDTH:0] w_carry;

  assign w_carry[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_half_adder
      assign sum[gi]        = a[gi] ^ w_carry[gi];
      assign w_carry[gi+1]  = a[gi] & w_carry[gi];
    end
  endgenerate

  assign cout = w_carry[WIDTH];

endmodule : inc_n

// File: rtl/program_counter.sv
// -----------------------------------------------------------------------------
// program_counter
// Hack CPU program counter: WIDTH-bit register with clear / load / increment /
// hold, gated by an advance enable. The output addresses the instruction ROM.
// Next-state priority (rst aside): en=0 hold > clr > load > inc > hold.
//
// Optional feature macro: PC_WRAP_FLAG_EN
//   When defined, adds the registered 'wrap' output, a one-cycle pulse after
//   an edge on which the increment branch rolled all-ones over to zero.
//
// Ports:
//   clk   in   1      system clock, rising edge
//   rst   in   1      synchronous reset, active-high (overrides en)
//   en    in   1      advance enable; 0 freezes the counter (CPU stall)
//   clr   in   1      functional clear to 0
//   load  in   1      load din (taken jump)
//   inc   in   1      increment by 1
//   din   in   WIDTH  jump target
//   out   out  WIDTH  current PC
//   wrap  out  1      [PC_WRAP_FLAG_EN only] increment wrap pulse
// -----------------------------------------------------------------------------
module program_counter
  import hack_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic             inc,
  input  logic [WIDTH-1:0] din,
`ifdef PC_WRAP_FLAG_EN
  output logic [WIDTH-1:0] out,
  output logic             wrap
`else
  output logic [WIDTH-1:0] out
`endif
);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_inc;
  logic             w_carry;
  logic [WIDTH-1:0] w_sel_inc;
  logic [WIDTH-1:0] w_sel_load;
  logic [WIDTH-1:0] w_sel_clr;
  logic [WIDTH-1:0] w_next;

  inc_n #(
    .WIDTH (WIDTH)
  ) u_inc (
    .a    (r_pc),
    .sum  (w_inc),
    .cout (w_carry)
  );

  // Per-bit 2:1 mux ladder; the innermost mux has the lowest priority, so the
  // chain naturally encodes en > clr > load > inc > hold.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit_mux
      assign w_sel_inc[gi]  = inc  ? w_inc[gi]      : r_pc[gi];
      assign w_sel_load[gi] = load ? din[gi]        : w_sel_inc[gi];
      assign w_sel_clr[gi]  = clr  ? 1'b0           : w_sel_load[gi];
      assign w_next[gi]     = en   ? w_sel_clr[gi]  : r_pc[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= PC_RESET_VAL[WIDTH-1:0];
    end else begin
      r_pc <= w_next;
    end
  end

  assign out = r_pc;

`ifdef PC_WRAP_FLAG_EN
  // Only the increment branch can raise the flag: clr/load to zero and a
  // frozen counter both leave it low.
  logic r_wrap;
  logic w_wrap_next;

  assign w_wrap_next = en & ~clr & ~load & inc & w_carry;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_wrap_next;
    end
  end

  assign wrap = r_wrap;
`else
  // Carry out has no consumer without the wrap flag.
  logic w_unused_carry;
  assign w_unused_carry = w_carry;
`endif

endmodule : program_counter
